// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-8 demultiplexer.
package demux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_idx_t;

  // One-hot write strobe for the addressed lane, gated by the accept condition.
  function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t idx, input logic en);
    logic [LANES-1:0] v;
    v = {LANES{1'b0}};
    v[idx] = en;
    return v;
  endfunction
endpackage

// File: rtl/demux_lane_reg.sv
// Single-entry register slice for one output lane: write has priority over drain,
// so a same-edge drain and write keeps the lane full with the new word.
module demux_lane_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_ready,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  // Occupancy flag: set on write, cleared on drain when not rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_valid <= 1'b1;
    end else if (r_valid && rd_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Data holds across drains and only changes on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= {W{1'b0}};
    end else if (wr_en) begin
      r_data <= wr_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
endmodule

// File: rtl/demux1to8_seq.sv
// Registered 1-to-8 demultiplexer with per-lane valid/ready slices and an accept counter.
// Define DEMUX_RR_EN to steer by a round-robin pointer instead of sel.
module demux1to8_seq
  import demux_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [SEL_W-1:0]     sel,
  output logic [LANES*W-1:0]   out_data,
  output logic [LANES-1:0]     out_valid,
  input  logic [LANES-1:0]     out_ready,
  output logic [CNT_W-1:0]     acc_cnt
);
  lane_idx_t        w_lane;
  logic             w_in_ready;
  logic             w_accept;
  logic [LANES-1:0] w_wr_en;
  logic [LANES-1:0] w_lane_valid;
  logic [CNT_W-1:0] r_acc_cnt;

`ifdef DEMUX_RR_EN
  lane_idx_t r_ptr;

  // Round-robin pointer: advances one lane per accept, never skips full lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 3'd1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_lane = r_ptr;
`else
  assign w_lane = sel;
`endif

  // Ready depends only on the addressed lane and its consumer, never on in_valid.
  always_comb begin
    w_in_ready = 1'b0;
    w_wr_en    = {LANES{1'b0}};
    if (rst) begin
      w_in_ready = 1'b0;
    end else begin
      w_in_ready = !w_lane_valid[w_lane] || out_ready[w_lane];
    end
    w_accept = in_valid && w_in_ready;
    w_wr_en  = lane_onehot(w_lane, w_accept);
  end

  // Accepted-word counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_acc_cnt <= r_acc_cnt;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane_reg #(.W(W)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (w_wr_en[g]),
      .wr_data  (in_data),
      .rd_ready (out_ready[g]),
      .valid    (w_lane_valid[g]),
      .data     (out_data[g*W +: W])
    );
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_lane_valid;
  assign acc_cnt   = r_acc_cnt;
endmodule

// File: tb/tb_demux1to8_seq.sv
// Directed self-checking bench for demux1to8_seq (W=8, CNT_W=16).
module tb_demux1to8_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  sel;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] acc_cnt;

  int checks   = 0;
  int failures = 0;

  demux1to8_seq #(.W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_cnt   (acc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input int k);
    return out_data[k*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; sel = 3'd0; out_ready = 8'h00;
    tick(); tick();
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_acc_cnt", acc_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data, 64'd0);
    rst = 1'b0; #1;
    chk("idle_in_ready", in_ready, 1'b1);

`ifdef DEMUX_RR_EN
    sel = 3'd3;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_data = 8'd8; #1;
    chk("rr_blocked_lane0", in_ready, 1'b0);
    tick();
    chk("rr_acc_8", acc_cnt, 16'd8);
    out_ready = 8'h01; #1;
    chk("rr_ready_after_drain0", in_ready, 1'b1);
    tick();
    out_ready = 8'h00; in_data = 8'd9; #1;
    chk("rr_lane0_data8", lane(0), 8'd8);
    chk("rr_acc_9", acc_cnt, 16'd9);
    chk("rr_blocked_lane1", in_ready, 1'b0);
    out_ready = 8'h02;
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    chk("rr_lane1_data9", lane(1), 8'd9);
    chk("rr_acc_10", acc_cnt, 16'd10);
    chk("rr_out_valid", out_valid, 8'hFF);
    for (int k = 2; k < 8; k++) chk($sformatf("rr_lane%0d", k), lane(k), 8'(k));
`else
    // Single steer to lane 5.
    sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("steer_out_valid", out_valid, 8'h20);
    chk("steer_lane5", lane(5), 8'hA5);
    chk("steer_acc", acc_cnt, 16'd1);
    // Backpressure on full lane 5.
    in_data = 8'h3C; in_valid = 1'b1; #1;
    chk("bp_in_ready", in_ready, 1'b0);
    tick();
    chk("bp_lane5_hold", lane(5), 8'hA5);
    chk("bp_acc", acc_cnt, 16'd1);
    // Simultaneous drain and write.
    out_ready = 8'h20; #1;
    chk("dw_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    chk("dw_lane5", lane(5), 8'h3C);
    chk("dw_out_valid", out_valid, 8'h20);
    chk("dw_acc", acc_cnt, 16'd2);
    // Drain; data must hold.
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00;
    chk("drain_out_valid", out_valid, 8'h00);
    chk("drain_lane5_hold", lane(5), 8'h3C);
    // Sweep all lanes.
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k); in_data = 8'h10 + 8'(k); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("sweep_out_valid", out_valid, 8'hFF);
    chk("sweep_acc", acc_cnt, 16'd10);
    for (int k = 0; k < 8; k++) chk($sformatf("sweep_lane%0d", k), lane(k), 8'h10 + 8'(k));
    out_ready = 8'hFF;
    tick();
    out_ready = 8'h00;
    chk("sweep_drain", out_valid, 8'h00);
    // sel wiggle with in_valid low.
    sel = 3'd2; in_data = 8'hEE;
    tick();
    chk("idle_sel_valid", out_valid, 8'h00);
    chk("idle_sel_acc", acc_cnt, 16'd10);
    // Reset mid-operation with a coinciding handshake.
    for (int k = 1; k < 4; k++) begin
      sel = 3'(k); in_data = 8'h50 + 8'(k); in_valid = 1'b1;
      tick();
    end
    chk("pre_rst_valid", out_valid, 8'h0E);
    chk("pre_rst_acc", acc_cnt, 16'd13);
    rst = 1'b1; sel = 3'd4; in_data = 8'h77; in_valid = 1'b1; #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 8'h00);
    chk("mid_rst_acc", acc_cnt, 16'd0);
    chk("mid_rst_lane4", lane(4), 8'h00);
    sel = 3'd0; in_data = 8'h99; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_acc", acc_cnt, 16'd1);
    chk("post_rst_lane0", lane(0), 8'h99);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
